// File: rtl/ttc_enc_pkg.sv
// ============================================================================
// Module  : ttc_enc_pkg
// Purpose : Shared constants, frame-kind enum and 6b/8b symbol lookups for
//           the RD53A-style TTC frame encoder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package ttc_enc_pkg;

  localparam logic [15:0] SYNC_WORD = 16'h817E;

  typedef enum logic [1:0] {
    FK_IDLE = 2'd0,
    FK_SYNC = 2'd1,
    FK_CMD  = 2'd2,
    FK_TRIG = 2'd3
  } frame_kind_t;

  // Trigger-pattern symbol; pattern 0 never produces a trigger frame.
  function automatic logic [7:0] trig_sym(input logic [3:0] pat);
    logic [7:0] sym;
    case (pat)
      4'd1:    sym = 8'h2B;
      4'd2:    sym = 8'h2D;
      4'd3:    sym = 8'h2E;
      4'd4:    sym = 8'h33;
      4'd5:    sym = 8'h35;
      4'd6:    sym = 8'h36;
      4'd7:    sym = 8'h39;
      4'd8:    sym = 8'h3A;
      4'd9:    sym = 8'h3C;
      4'd10:   sym = 8'h4B;
      4'd11:   sym = 8'h4D;
      4'd12:   sym = 8'h4E;
      4'd13:   sym = 8'h53;
      4'd14:   sym = 8'h55;
      4'd15:   sym = 8'h56;
      default: sym = 8'h00;
    endcase
    return sym;
  endfunction

  // Data symbol carrying a 5-bit value (used for the trigger tag).
  function automatic logic [7:0] data_sym(input logic [4:0] val);
    logic [255:0] table_bits;
    table_bits = {8'h6A, 8'h6C, 8'h71, 8'h72, 8'h74, 8'h8B, 8'h8D, 8'h8E,
                  8'h93, 8'h95, 8'h96, 8'h99, 8'h9A, 8'h9C, 8'hA3, 8'hA5,
                  8'hA6, 8'hA9, 8'hAA, 8'hAC, 8'hB1, 8'hB2, 8'hB4, 8'hC3,
                  8'hC5, 8'hC6, 8'hC9, 8'hCA, 8'hCC, 8'hD1, 8'hD2, 8'hD4};
    return table_bits[8'd255 - {val, 3'b000} -: 8];
  endfunction

endpackage

`default_nettype wire

// File: rtl/ttc_trig_accum.sv
// ============================================================================
// Module  : ttc_trig_accum
// Purpose : Owns the 4-BX window slot counter and collects the per-BX
//           trigger samples into the window pattern (first BX = MSB).
// Ports   : clk, rst (async, active-low), trigger  -> inputs
//           slot[1:0]     current BX position in the window
//           pat_full[3:0] complete window pattern (valid when win_end)
//           win_end       last BX of the window (slot 3)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ttc_trig_accum (
  input  logic       clk,
  input  logic       rst,
  input  logic       trigger,
  output logic [1:0] slot,
  output logic [3:0] pat_full,
  output logic       win_end
);

  logic [1:0] r_slot;
  // Bit 0 is never stored: the slot-3 sample is used combinationally.
  logic [3:1] r_pattern;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_slot    <= 2'd0;
      r_pattern <= 3'd0;
    end else begin
      r_slot <= r_slot + 2'd1;
      case (r_slot)
        2'd0:    r_pattern[3] <= trigger;
        2'd1:    r_pattern[2] <= trigger;
        2'd2:    r_pattern[1] <= trigger;
        default: r_pattern    <= r_pattern;
      endcase
    end
  end

  assign slot     = r_slot;
  assign win_end  = (r_slot == 2'd3);
  assign pat_full = {r_pattern, trigger};

endmodule

`default_nettype wire

// File: rtl/ttc_frame_encoder.sv
// ============================================================================
// Module  : ttc_frame_encoder
// Purpose : Builds one 16-bit TTC frame per 4-BX window from triggers and
//           queued command words (priority TRIG > SYNC > CMD > IDLE).
// Ports   : clk, rst (async, active-low), trigger, cmd_data[15:0], cmd_valid
//           cmd_ready      command accepted when cmd_valid && cmd_ready
//           frame_data     encoded frame, [15:8] is sent first
//           frame_valid    one-cycle strobe per window
//           frame_is_trig  frame carries a trigger
//           trig_tag[4:0]  tag of the trigger frame
//           trig_frame_cnt, cmd_frame_cnt (only with TTC_ENC_STATS_EN)
// Config  : define TTC_ENC_STATS_EN to add the saturating frame counters.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ttc_frame_encoder
  import ttc_enc_pkg::*;
#(
  parameter int          SYNC_MAX  = 32,
  parameter logic [15:0] IDLE_WORD = 16'h6969
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trigger,
  input  logic [15:0] cmd_data,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  output logic [15:0] frame_data,
  output logic        frame_valid,
  output logic        frame_is_trig,
  output logic [4:0]  trig_tag
`ifdef TTC_ENC_STATS_EN
  ,
  output logic [15:0] trig_frame_cnt,
  output logic [15:0] cmd_frame_cnt
`endif
);

  localparam int            SW        = $clog2(SYNC_MAX);
  localparam logic [SW-1:0] SYNC_LAST = SW'(SYNC_MAX - 1);

  logic [1:0]    w_slot;
  logic [3:0]    w_pat_full;
  logic          w_win_end;
  logic          w_sync_due;
  frame_kind_t   w_kind;
  logic [15:0]   w_frame;

  logic [4:0]    r_tag;
  logic [SW-1:0] r_since_sync;

  ttc_trig_accum u_accum (
    .clk      (clk),
    .rst      (rst),
    .trigger  (trigger),
    .slot     (w_slot),
    .pat_full (w_pat_full),
    .win_end  (w_win_end)
  );

  assign w_sync_due = (r_since_sync >= SYNC_LAST);
  // Combinational from trigger: a slot-3 trigger must still win the window.
  assign cmd_ready  = (w_slot == 2'd3) && (w_pat_full == 4'd0) && !w_sync_due;

  always_comb begin
    w_kind  = FK_IDLE;
    w_frame = IDLE_WORD;
    if (w_pat_full != 4'd0) begin
      w_kind  = FK_TRIG;
      w_frame = {trig_sym(w_pat_full), data_sym(r_tag)};
    end else if (w_sync_due) begin
      w_kind  = FK_SYNC;
      w_frame = SYNC_WORD;
    end else if (cmd_valid) begin
      w_kind  = FK_CMD;
      w_frame = cmd_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_data    <= 16'd0;
      frame_valid   <= 1'b0;
      frame_is_trig <= 1'b0;
      trig_tag      <= 5'd0;
      r_tag         <= 5'd0;
      r_since_sync  <= SYNC_LAST;
    end else begin
      frame_valid <= w_win_end;
      if (w_win_end) begin
        frame_data    <= w_frame;
        frame_is_trig <= (w_kind == FK_TRIG);
        if (w_kind == FK_TRIG) begin
          trig_tag <= r_tag;
          r_tag    <= r_tag + 5'd1;
        end
        if (w_kind == FK_SYNC) begin
          r_since_sync <= '0;
        end else if (r_since_sync != SYNC_LAST) begin
          r_since_sync <= r_since_sync + SW'(1);
        end
      end
    end
  end

`ifdef TTC_ENC_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trig_frame_cnt <= 16'd0;
      cmd_frame_cnt  <= 16'd0;
    end else if (w_win_end) begin
      if (w_kind == FK_TRIG && trig_frame_cnt != 16'hFFFF) begin
        trig_frame_cnt <= trig_frame_cnt + 16'd1;
      end
      if (w_kind == FK_CMD && cmd_frame_cnt != 16'hFFFF) begin
        cmd_frame_cnt <= cmd_frame_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

`default_nettype wire
